// File: rtl/alu_ctrl_pkg.sv
// Shared encodings, defaults and state type for the ALU control sequencer.
package alu_ctrl_pkg;

  localparam int unsigned DEF_ALUOP_W  = 2;
  localparam int unsigned DEF_OPCODE_W = 6;
  localparam int unsigned DEF_SEL_W    = 3;
  localparam int unsigned DEF_MC_LAT   = 4;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;
  localparam logic [1:0] ALUOP_RSVD = 2'b11;

  localparam logic [2:0] DEF_ADD_SEL = 3'b010;
  localparam logic [2:0] DEF_SUB_SEL = 3'b011;
  localparam logic [7:0] DEF_MC_MASK = 8'b1100_0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXEC    = 2'd1,
    MC_WAIT = 2'd2
  } state_e;

endpackage

// File: rtl/alu_sel_decode.sv
// Combinational ALUOp/opcode decode into ALU select, multi-cycle class and illegal flag.
// ALU_CTRL_ILLEGAL_TRAP_EN: ALUOp=11 flagged illegal instead of using the opcode path.
module alu_sel_decode
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned             ALUOP_W  = DEF_ALUOP_W,
  parameter int unsigned             OPCODE_W = DEF_OPCODE_W,
  parameter int unsigned             SEL_W    = DEF_SEL_W,
  parameter logic [SEL_W-1:0]        ADD_SEL  = DEF_ADD_SEL,
  parameter logic [SEL_W-1:0]        SUB_SEL  = DEF_SUB_SEL,
  parameter logic [(1<<SEL_W)-1:0]   MC_MASK  = DEF_MC_MASK
) (
  input  logic [ALUOP_W-1:0]  alu_op_i,
  input  logic [OPCODE_W-1:0] opcode_i,
  output logic [SEL_W-1:0]    sel_c,
  output logic                is_mc_c,
  output logic                illegal_c
);

  // Only the low function bits select the ALU operation.
  logic unused_opcode_hi;
  assign unused_opcode_hi = ^opcode_i[OPCODE_W-1:SEL_W];

  always_comb begin
    sel_c     = opcode_i[SEL_W-1:0];
    illegal_c = 1'b0;
    case (alu_op_i)
      ALUOP_W'(ALUOP_ADD):  sel_c = ADD_SEL;
      ALUOP_W'(ALUOP_SUB):  sel_c = SUB_SEL;
      ALUOP_W'(ALUOP_FUNC): sel_c = opcode_i[SEL_W-1:0];
      default: begin
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
        sel_c     = '0;
        illegal_c = 1'b1;
`else
        sel_c     = opcode_i[SEL_W-1:0];
`endif
      end
    endcase
    is_mc_c = MC_MASK[sel_c] & ~illegal_c;
  end

endmodule

// File: rtl/alu_ctrl_sequencer.sv
// Registered ALU select with valid/ready request handshake and multi-cycle sequencing.
// ALU_CTRL_ILLEGAL_TRAP_EN: ALUOp=11 raises a one-cycle err pulse instead of executing.
module alu_ctrl_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned             ALUOP_W  = DEF_ALUOP_W,
  parameter int unsigned             OPCODE_W = DEF_OPCODE_W,
  parameter int unsigned             SEL_W    = DEF_SEL_W,
  parameter logic [SEL_W-1:0]        ADD_SEL  = DEF_ADD_SEL,
  parameter logic [SEL_W-1:0]        SUB_SEL  = DEF_SUB_SEL,
  parameter logic [(1<<SEL_W)-1:0]   MC_MASK  = DEF_MC_MASK,
  parameter int unsigned             MC_LAT   = DEF_MC_LAT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ALUOP_W-1:0]  alu_op,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                flush,
  output logic [SEL_W-1:0]    alu_sel,
  output logic                sel_valid,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int unsigned CNT_W = $clog2(MC_LAT);

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  alu_sel_q, alu_sel_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              sel_valid_q, sel_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [SEL_W-1:0]  dec_sel;
  logic              dec_is_mc;
  logic              dec_illegal;
  logic              handshake;

  alu_sel_decode #(
    .ALUOP_W  (ALUOP_W),
    .OPCODE_W (OPCODE_W),
    .SEL_W    (SEL_W),
    .ADD_SEL  (ADD_SEL),
    .SUB_SEL  (SUB_SEL),
    .MC_MASK  (MC_MASK)
  ) u_decode (
    .alu_op_i  (alu_op),
    .opcode_i  (opcode),
    .sel_c     (dec_sel),
    .is_mc_c   (dec_is_mc),
    .illegal_c (dec_illegal)
  );

  assign req_ready = (state_q == IDLE);
  // A flush in IDLE blocks acceptance that cycle.
  assign handshake = req_valid & req_ready & ~flush;

  always_comb begin
    state_d   = state_q;
    alu_sel_d = alu_sel_q;
    count_d   = count_q;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (handshake) begin
          alu_sel_d = dec_sel;
          if (dec_illegal) begin
            err_d = 1'b1;
          end else if (dec_is_mc) begin
            state_d = MC_WAIT;
            count_d = CNT_W'(MC_LAT - 1);
          end else begin
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        state_d = IDLE;
      end
      MC_WAIT: begin
        if (flush || count_q == '0) begin
          state_d = IDLE;
          count_d = '0;
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase

    // Status outputs are registered images of the upcoming state.
    sel_valid_d = (state_d != IDLE);
    busy_d      = (state_d == MC_WAIT);
    done_d      = (state_d == EXEC) || ((state_d == MC_WAIT) && (count_d == '0));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      alu_sel_q   <= '0;
      count_q     <= '0;
      sel_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      alu_sel_q   <= alu_sel_d;
      count_q     <= count_d;
      sel_valid_q <= sel_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign alu_sel   = alu_sel_q;
  assign sel_valid = sel_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_ctrl_sequencer.sv
// Scoreboard bench for alu_ctrl_sequencer: expected done/err events queued at handshake.
module tb_alu_ctrl_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] alu_op;
  logic [5:0] opcode;
  logic       flush;
  logic [2:0] alu_sel;
  logic       sel_valid;
  logic       busy;
  logic       done;
  logic       err;

  typedef struct {
    logic       is_err;
    logic [2:0] sel;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  alu_ctrl_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .alu_op    (alu_op),
    .opcode    (opcode),
    .flush     (flush),
    .alu_sel   (alu_sel),
    .sel_valid (sel_valid),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done/err pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && (done || err)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got done=%0b err=%0b expected none (cycle %0d)", done, err, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pulse_done", 32'(done), 32'(!e.is_err));
        check("pulse_err", 32'(err), 32'(e.is_err));
        check("pulse_sel", 32'(alu_sel), 32'(e.sel));
        check("pulse_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Hold a request until accepted; optionally queue the expected response.
  task automatic send(input logic [1:0] op, input logic [5:0] opc, input bit expect_rsp,
                      input logic is_err, input logic [2:0] sel, input int lat);
    int waited = 0;
    req_valid = 1'b1;
    alu_op    = op;
    opcode    = opc;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got req_ready=0 expected 1 within 20 cycles");
    end else if (expect_rsp) begin
      exp_t e;
      e.is_err = is_err;
      e.sel    = sel;
      e.cyc    = cyc + lat;
      sb.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0;
    alu_op    = 2'b00;
    opcode    = 6'b000000;
    flush     = 1'b0;
  endtask

  task automatic check_quiet(input string name);
    check({name, "_sel"}, 32'(alu_sel), 32'h0);
    check({name, "_sel_valid"}, 32'(sel_valid), 32'h0);
    check({name, "_busy"}, 32'(busy), 32'h0);
    check({name, "_done"}, 32'(done), 32'h0);
    check({name, "_err"}, 32'(err), 32'h0);
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    check_quiet("por");
    reset = 1'b0;
    @(negedge clk);
    check("por_ready", 32'(req_ready), 32'h1);

    // ADD path: done one cycle after handshake
    send(2'b00, 6'b111111, 1'b1, 1'b0, 3'b010, 1);
    check("add_sel_valid", 32'(sel_valid), 32'h1);
    check("add_ready_low", 32'(req_ready), 32'h0);
    idle_inputs();
    @(negedge clk);
    check("add_ready_back", 32'(req_ready), 32'h1);

    // Multi-cycle opcode 110: busy for four cycles, select stable
    send(2'b10, 6'b000110, 1'b1, 1'b0, 3'b110, 4);
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      check("mc_busy", 32'(busy), 32'h1);
      check("mc_sel", 32'(alu_sel), 32'h6);
      @(negedge clk);
    end
    check("mc_busy_end", 32'(busy), 32'h0);
    check("mc_ready_end", 32'(req_ready), 32'h1);

    // Flush on second MC_WAIT cycle: no done, select retained
    send(2'b10, 6'b000110, 1'b0, 1'b0, 3'b110, 4);
    idle_inputs();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 32'(busy), 32'h0);
    check("flush_sel_valid", 32'(sel_valid), 32'h0);
    check("flush_ready", 32'(req_ready), 32'h1);
    check("flush_sel_kept", 32'(alu_sel), 32'h6);
    repeat (4) @(negedge clk);

    // Reserved ALUOp
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    send(2'b11, 6'b000001, 1'b1, 1'b1, 3'b000, 1);
    idle_inputs();
    check("rsvd_ready", 32'(req_ready), 32'h1);
    check("rsvd_sel_valid", 32'(sel_valid), 32'h0);
`else
    send(2'b11, 6'b000001, 1'b1, 1'b0, 3'b001, 1);
    idle_inputs();
    check("rsvd_err", 32'(err), 32'h0);
    check("rsvd_sel", 32'(alu_sel), 32'h1);
`endif
    repeat (2) @(negedge clk);

    // Back-to-back SUB then ADD with req_valid held
    send(2'b01, 6'b000000, 1'b1, 1'b0, 3'b011, 1);
    send(2'b00, 6'b000000, 1'b1, 1'b0, 3'b010, 1);
    idle_inputs();
    @(negedge clk);

    // Opcode path ignores the upper opcode bits
    send(2'b10, 6'b101101, 1'b1, 1'b0, 3'b101, 1);
    idle_inputs();
    @(negedge clk);

    // Reset held three cycles in the middle of an MC_WAIT on select 111
    send(2'b10, 6'b000111, 1'b0, 1'b0, 3'b111, 4);
    idle_inputs();
    check("mc7_busy", 32'(busy), 32'h1);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_quiet("midrst");
    reset = 1'b0;
    @(negedge clk);
    check("midrst_ready", 32'(req_ready), 32'h1);
    check("midrst_busy", 32'(busy), 32'h0);

    // Flush in IDLE blocks the handshake
    req_valid = 1'b1;
    alu_op    = 2'b00;
    flush     = 1'b1;
    @(negedge clk);
    idle_inputs();
    check("idle_flush_ready", 32'(req_ready), 32'h1);
    check("idle_flush_sel_valid", 32'(sel_valid), 32'h0);
    check("idle_flush_sel", 32'(alu_sel), 32'h0);

    repeat (6) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
